// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: holds HI/LO, counts the op latency
// and raises the D-stage stall for MDU-class instructions that must wait.
module mdu_sequencer #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  mdu_type,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        d_uses_mdu,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_CYCLES);
  localparam logic [3:0] DIV_CNT = 4'(DIV_CYCLES);

  localparam logic [3:0] T_MULT  = 4'd1;
  localparam logic [3:0] T_MULTU = 4'd2;
  localparam logic [3:0] T_DIV   = 4'd3;
  localparam logic [3:0] T_DIVU  = 4'd4;
  localparam logic [3:0] T_MFHI  = 4'd5;
  localparam logic [3:0] T_MFLO  = 4'd6;
  localparam logic [3:0] T_MTHI  = 4'd7;
  localparam logic [3:0] T_MTLO  = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic        div_zero;
  logic        go;
  logic        commit;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_safe;
  logic [31:0] q_s, r_s, q_u, r_u;

  assign go     = start && !cancel && (state == IDLE);
  assign busy   = (state != IDLE);
  assign stall  = d_uses_mdu && (busy || (start && (mdu_type >= T_MULT) && (mdu_type <= T_DIVU)));
  assign commit = busy && (cnt == 4'd1);

  always_comb begin
    rd_data = 32'd0;
    if (mdu_type == T_MFHI)      rd_data = hi;
    else if (mdu_type == T_MFLO) rd_data = lo;
  end

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Divisor forced to 1 on b==0 so the datapath never divides by zero; the result is discarded.
  always_comb begin
    div_safe = (b == 32'd0) ? 32'd1 : b;
    q_u      = a / div_safe;
    r_u      = a % div_safe;
    q_s      = 32'($signed(a) / $signed(div_safe));
    r_s      = 32'($signed(a) % $signed(div_safe));
    if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
      q_s = 32'h8000_0000;
      r_s = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (go) begin
          if ((mdu_type == T_MULT) || (mdu_type == T_MULTU))    state_nxt = MUL;
          else if ((mdu_type == T_DIV) || (mdu_type == T_DIVU)) state_nxt = DIV;
        end
      end
      MUL, DIV: if (cnt == 4'd1) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= 4'd0;
      res_hi   <= 32'd0;
      res_lo   <= 32'd0;
      div_zero <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else if (go) begin
      case (mdu_type)
        T_MULT:  begin {res_hi, res_lo} <= prod_s; div_zero <= 1'b0; cnt <= MUL_CNT; end
        T_MULTU: begin {res_hi, res_lo} <= prod_u; div_zero <= 1'b0; cnt <= MUL_CNT; end
        T_DIV:   begin res_hi <= r_s; res_lo <= q_s; div_zero <= (b == 32'd0); cnt <= DIV_CNT; end
        T_DIVU:  begin res_hi <= r_u; res_lo <= q_u; div_zero <= (b == 32'd0); cnt <= DIV_CNT; end
        T_MTHI:  hi <= a;
        T_MTLO:  lo <= a;
        default: ;
      endcase
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (commit && !div_zero) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: table of single operations with expected latency and HI/LO,
// followed by hand-written stall, cancel, MTHI-stall and mid-operation reset sequences.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  mdu_type;
  logic [31:0] a, b;
  logic        cancel;
  logic        d_uses_mdu;
  logic        busy, stall;
  logic [31:0] hi, lo, rd_data;

  int total = 0;
  int bad   = 0;

  mdu_sequencer #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_type(mdu_type),
    .a(a), .b(b), .cancel(cancel), .d_uses_mdu(d_uses_mdu),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one op in cycle 0, then counts busy cycles (bounded) and leaves us in cycle N+1.
  task automatic run_op(input vec_t v);
    int n;
    @(negedge clk);
    start = 1'b1; mdu_type = v.op; a = v.a; b = v.b;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0; a = 32'd0; b = 32'd0;
    #1;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({v.name, " busy_cycles"}, 32'(n), 32'(v.cyc));
    check({v.name, " hi"}, hi, v.hi);
    check({v.name, " lo"}, lo, v.lo);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"mult_neg",     4'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
    vecs[1]  = '{"multu_max",    4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5};
    vecs[2]  = '{"div_neg7_2",   4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
    vecs[3]  = '{"mthi",         4'd7, 32'h0000_0011, 32'd0,         32'h0000_0011, 32'hFFFF_FFFD, 0};
    vecs[4]  = '{"mtlo",         4'd8, 32'h0000_0022, 32'd0,         32'h0000_0011, 32'h0000_0022, 0};
    vecs[5]  = '{"divu_by_zero", 4'd4, 32'h0000_1234, 32'd0,         32'h0000_0011, 32'h0000_0022, 10};
    vecs[6]  = '{"div_overflow", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
    vecs[7]  = '{"divu_100_7",   4'd4, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 10};
    vecs[8]  = '{"div_7_neg2",   4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
    vecs[9]  = '{"mult_minsq",   4'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 5};
    vecs[10] = '{"multu_2p32",   4'd2, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 5};

    reset = 1'b1; start = 1'b0; mdu_type = 4'd0; a = 32'd0; b = 32'd0;
    cancel = 1'b0; d_uses_mdu = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset stall", {31'd0, stall}, 32'd0);
    check("reset hi", hi, 32'd0);
    check("reset lo", lo, 32'd0);

    foreach (vecs[i]) run_op(vecs[i]);

    // MFLO waiting in D behind a MULT: stalls cycles 0..5, reads the product in cycle 6.
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd1; a = 32'd6; b = 32'd7; d_uses_mdu = 1'b1;
    #1;
    check("stall cyc0", {31'd0, stall}, 32'd1);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0; mdu_type = 4'd0; a = 32'd0; b = 32'd0;
      #1;
      check($sformatf("stall cyc%0d", c), {31'd0, stall}, 32'd1);
    end
    @(negedge clk);
    mdu_type = 4'd6; d_uses_mdu = 1'b0;
    #1;
    check("stall cyc6", {31'd0, stall}, 32'd0);
    check("mflo rd_data", rd_data, 32'd42);
    mdu_type = 4'd5;
    #1;
    check("mfhi rd_data", rd_data, 32'd0);
    mdu_type = 4'd0;
    #1;
    check("none rd_data", rd_data, 32'd0);

    // MTHI in D on an idle unit never stalls.
    start = 1'b1; mdu_type = 4'd7; a = 32'h55; d_uses_mdu = 1'b1; cancel = 1'b1;
    #1;
    check("mthi no stall", {31'd0, stall}, 32'd0);

    // Start with cancel: raw start still drives stall, but nothing commits.
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd1; a = 32'd3; b = 32'd3; cancel = 1'b1; d_uses_mdu = 1'b1;
    #1;
    check("cancel raw stall", {31'd0, stall}, 32'd1);
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0; cancel = 1'b0; d_uses_mdu = 1'b0;
    #1;
    check("cancel busy", {31'd0, busy}, 32'd0);
    repeat (6) @(negedge clk);
    #1;
    check("cancel hi", hi, 32'd0);
    check("cancel lo", lo, 32'd42);

    // Reset during busy cycle 3 aborts the operation.
    @(negedge clk);
    start = 1'b1; mdu_type = 4'd1; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0; mdu_type = 4'd0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("pre-reset busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("midop reset busy", {31'd0, busy}, 32'd0);
    check("midop reset hi", hi, 32'd0);
    check("midop reset lo", lo, 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("no late commit lo", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
